tiny_dnn_ctrl: RTL and testbench

- Sequencer that drives the tiny_dnn_top compute array from the host side. It is the initiator of the write/init/exec/a/w/d protocol and the consumer of x.
- Streams weights in over a valid/ready channel, then streams input vectors in the same way. For each vector it runs init, exec over f_size elements and readout of f_num sums.
- Results leave on a valid/ready output stream. It sits between the host DMA/testbench streams and tiny_dnn_top.

---
 rtl/tiny_dnn_pkg.sv | 37 +++
 rtl/tiny_dnn_ctrl_rdq.sv | 91 +++++++++
 rtl/tiny_dnn_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_tiny_dnn_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_dnn_pkg.sv
// Shared types and constants for the tiny_dnn host-side sequencer.
// The optional TINY_DNN_CTRL_PERF_EN build adds performance counters to the top.
package tiny_dnn_pkg;

  localparam int F_NUM  = 16;
  localparam int F_SIZE = 512;
  localparam int A_W    = 13;
  localparam int IDX_W  = 4;
  localparam int EL_W   = 9;

  localparam logic [A_W-1:0]   K_LAST = A_W'(F_NUM * F_SIZE - 1);
  localparam logic [EL_W-1:0]  J_LAST = EL_W'(F_SIZE - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(F_NUM - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    EXEC = 3'd3,
    RD   = 3'd4,
    DONE = 3'd5
  } state_e;

  // Readout slice phases: address issued -> array registers x -> capture -> hold for y_ready.
  typedef enum logic [1:0] {
    RQ_IDLE = 2'd0,
    RQ_WAIT = 2'd1,
    RQ_CAP  = 2'd2,
    RQ_HOLD = 2'd3
  } rq_phase_e;

  function automatic logic [A_W-1:0] pack_addr(input logic [IDX_W-1:0] neuron,
                                               input logic [EL_W-1:0]  element);
    return {neuron, element};
  endfunction

endpackage

// File: rtl/tiny_dnn_ctrl_rdq.sv
// Readout slice: walks neurons 0..F_NUM-1, waits for the registered array result,
// captures it and holds it on the y stream until the consumer takes it.
module tiny_dnn_ctrl_rdq
  import tiny_dnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  real              x,
  input  logic             y_ready,
  output logic             addr_vld,
  output logic [IDX_W-1:0] addr_idx,
  output logic             last_acc,
  output logic             y_valid,
  output real              y_data,
  output logic [IDX_W-1:0] y_idx,
  output rq_phase_e        phase
);

  rq_phase_e        phase_q, phase_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic             y_valid_q, y_valid_d;
  real              y_data_q, y_data_d;
  logic [IDX_W-1:0] y_idx_q, y_idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= RQ_IDLE;
      i_q       <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= 0.0;
      y_idx_q   <= '0;
    end else begin
      phase_q   <= phase_d;
      i_q       <= i_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_idx_q   <= y_idx_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    i_d       = i_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_idx_d   = y_idx_q;
    addr_vld  = 1'b0;
    addr_idx  = i_q;
    last_acc  = 1'b0;
    case (phase_q)
      RQ_IDLE: begin
        if (active) begin
          addr_vld = 1'b1;
          addr_idx = '0;
          i_d      = '0;
          phase_d  = RQ_WAIT;
        end
      end
      RQ_WAIT: phase_d = RQ_CAP;
      RQ_CAP: begin
        y_data_d  = x;
        y_idx_d   = i_q;
        y_valid_d = 1'b1;
        phase_d   = RQ_HOLD;
      end
      RQ_HOLD: begin
        // The handshake edge doubles as the address edge of the next neuron.
        if (y_ready) begin
          y_valid_d = 1'b0;
          if (i_q == I_LAST) begin
            last_acc = 1'b1;
            phase_d  = RQ_IDLE;
          end else begin
            i_d      = i_q + 4'd1;
            addr_vld = 1'b1;
            addr_idx = i_q + 4'd1;
            phase_d  = RQ_WAIT;
          end
        end
      end
      default: phase_d = RQ_IDLE;
    endcase
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_idx   = y_idx_q;
  assign phase   = phase_q;

endmodule

// File: rtl/tiny_dnn_ctrl.sv
// Host-side sequencer for the tiny_dnn_top array: weight load, per-vector init/exec/readout.
// Define TINY_DNN_CTRL_PERF_EN to add the perf_cycles / perf_stall counters.
module tiny_dnn_ctrl
  import tiny_dnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load_w,
  input  logic [15:0]      num_vec,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  input  real              w_data,
  input  logic             d_valid,
  output logic             d_ready,
  input  real              d_data,
  output logic             y_valid,
  input  logic             y_ready,
  output real              y_data,
  output logic [IDX_W-1:0] y_idx,
  output logic             write,
  output logic             init,
  output logic             exec,
  output logic [A_W-1:0]   a,
  output real              w,
  output real              d,
  input  real              x,
  output state_e           dbg_state,
  output rq_phase_e        dbg_rd_phase
`ifdef TINY_DNN_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall
`endif
);

  state_e           state_q, state_d;
  logic [A_W-1:0]   k_q, k_d;
  logic [EL_W-1:0]  j_q, j_d;
  logic [15:0]      vec_q, vec_d;
  logic [15:0]      num_vec_q, num_vec_d;
  logic             write_q, write_d;
  logic             init_q, init_d;
  logic             exec_q, exec_d;
  logic             done_q, done_d;
  logic [A_W-1:0]   a_q, a_d;
  real              w_q, w_d;
  real              d_q, d_d;

  logic             rd_addr_vld;
  logic [IDX_W-1:0] rd_addr_idx;
  logic             rd_last;

  tiny_dnn_ctrl_rdq u_rdq (
    .clk      (clk),
    .reset    (reset),
    .active   (state_q == RD),
    .x        (x),
    .y_ready  (y_ready),
    .addr_vld (rd_addr_vld),
    .addr_idx (rd_addr_idx),
    .last_acc (rd_last),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_idx    (y_idx),
    .phase    (dbg_rd_phase)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      j_q       <= '0;
      vec_q     <= '0;
      num_vec_q <= '0;
      write_q   <= 1'b0;
      init_q    <= 1'b0;
      exec_q    <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      w_q       <= 0.0;
      d_q       <= 0.0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      j_q       <= j_d;
      vec_q     <= vec_d;
      num_vec_q <= num_vec_d;
      write_q   <= write_d;
      init_q    <= init_d;
      exec_q    <= exec_d;
      done_q    <= done_d;
      a_q       <= a_d;
      w_q       <= w_d;
      d_q       <= d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    j_d       = j_q;
    vec_d     = vec_q;
    num_vec_d = num_vec_q;
    write_d   = 1'b0;
    init_d    = 1'b0;
    exec_d    = 1'b0;
    done_d    = 1'b0;
    a_d       = a_q;
    w_d       = w_q;
    d_d       = d_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_vec_d = num_vec;
          vec_d     = '0;
          k_d       = '0;
          if (load_w)             state_d = LOAD;
          else if (num_vec == '0) state_d = DONE;
          else                    state_d = INIT;
        end
      end
      LOAD: begin
        if (w_valid) begin
          write_d = 1'b1;
          a_d     = k_q;
          w_d     = w_data;
          k_d     = k_q + 13'd1;
          if (k_q == K_LAST) state_d = (num_vec_q == '0) ? DONE : INIT;
        end
      end
      INIT: begin
        init_d  = 1'b1;
        a_d     = '0;
        j_d     = '0;
        state_d = EXEC;
      end
      EXEC: begin
        // A stalled input cycle leaves exec low, so the array sees a pure bubble.
        if (d_valid) begin
          exec_d = 1'b1;
          a_d    = pack_addr('0, j_q);
          d_d    = d_data;
          j_d    = j_q + 9'd1;
          if (j_q == J_LAST) state_d = RD;
        end
      end
      RD: begin
        if (rd_addr_vld) a_d = pack_addr(rd_addr_idx, '0);
        if (rd_last) begin
          vec_d   = vec_q + 16'd1;
          state_d = (({1'b0, vec_q} + 17'd1) < {1'b0, num_vec_q}) ? INIT : DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign w_ready   = (state_q == LOAD);
  assign d_ready   = (state_q == EXEC);
  assign write     = write_q;
  assign init      = init_q;
  assign exec      = exec_q;
  assign a         = a_q;
  assign w         = w_q;
  assign d         = d_q;
  assign dbg_state = state_q;

`ifdef TINY_DNN_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  always_comb begin
    stall_cyc = ((state_q == LOAD) && !w_valid) ||
                ((state_q == EXEC) && !d_valid) ||
                ((state_q == RD) && y_valid && !y_ready);
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if ((state_q == IDLE) && start) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy && !(&perf_cycles_q))     perf_cycles_d = perf_cycles_q + 32'd1;
      if (stall_cyc && !(&perf_stall_q)) perf_stall_d  = perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_tiny_dnn_ctrl.sv
// Directed bench for tiny_dnn_ctrl with a behavioural model of the tiny_dnn_top array.
module tb_tiny_dnn_ctrl;
  import tiny_dnn_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             load_w = 1'b0;
  logic [15:0]      num_vec = '0;
  logic             busy, done;
  logic             w_valid = 1'b0;
  logic             w_ready;
  real              w_data = 0.0;
  logic             d_valid = 1'b0;
  logic             d_ready;
  real              d_data = 0.0;
  logic             y_valid;
  logic             y_ready = 1'b1;
  real              y_data;
  logic [IDX_W-1:0] y_idx;
  logic             write, init, exec;
  logic [A_W-1:0]   a;
  real              w, d;
  real              x_r = 0.0;
  state_e           dbg_state;
  rq_phase_e        dbg_rd_phase;
`ifdef TINY_DNN_CTRL_PERF_EN
  logic [31:0]      perf_cycles, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tiny_dnn_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_w       (load_w),
    .num_vec      (num_vec),
    .busy         (busy),
    .done         (done),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_data       (d_data),
    .y_valid      (y_valid),
    .y_ready      (y_ready),
    .y_data       (y_data),
    .y_idx        (y_idx),
    .write        (write),
    .init         (init),
    .exec         (exec),
    .a            (a),
    .w            (w),
    .d            (d),
    .x            (x_r),
    .dbg_state    (dbg_state),
    .dbg_rd_phase (dbg_rd_phase)
`ifdef TINY_DNN_CTRL_PERF_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_stall   (perf_stall)
`endif
  );

  // Array model: weight memory, one accumulator per core, x registered from a.
  real wt [0:F_NUM*F_SIZE-1];
  real acc_sum [0:F_NUM-1];

  always @(posedge clk) begin
    if (write) wt[a] <= w;
    for (int n = 0; n < F_NUM; n++) begin
      if (init)      acc_sum[n] <= 0.0;
      else if (exec) acc_sum[n] <= acc_sum[n] + wt[n*F_SIZE + int'(a[8:0])] * d;
    end
    x_r <= acc_sum[a[12:9]];
  end

  // Free-running monitors; tests take differences across a job.
  logic exp_exec = 1'b0;
  int mon_busy = 0, mon_write = 0, mon_init = 0, mon_exec_bad = 0;
  int mon_both = 0, mon_bubble = 0;

  always @(posedge clk) exp_exec <= !reset && d_valid && d_ready;

  always @(negedge clk) begin
    if (busy === 1'b1)                  mon_busy++;
    if (write === 1'b1)                 mon_write++;
    if (init === 1'b1)                  mon_init++;
    if (exec !== exp_exec)              mon_exec_bad++;
    if (init === 1'b1 && exec === 1'b1) mon_both++;
    if (d_ready === 1'b1 && d_valid == 1'b0) mon_bubble++;
  end

  int w_bad = 0, y_bad = 0, hold_bad = 0, gap_bad = 0, stall_seen = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic lw, input logic [15:0] nv);
    start = 1'b1; load_w = lw; num_vec = nv;
    tick();
    start = 1'b0; load_w = 1'b0;
  endtask

  task automatic drive_w(input bit ramp, output int acc);
    int cyc;
    bit got;
    real val;
    acc = 0; cyc = 0; w_bad = 0;
    while (acc < F_NUM*F_SIZE && cyc < 20000) begin
      val = ramp ? acc * 0.5 : 1.0;
      w_valid = 1'b1; w_data = val;
      got = w_ready;
      tick(); cyc++;
      if (got) begin
        if (write !== 1'b1 || a !== A_W'(acc) || w != val) w_bad++;
        acc++;
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic drive_d(input int nvec, input real base, input bit gappy,
                         input int max_acc, output int acc);
    int cyc;
    bit tog, got;
    acc = 0; cyc = 0; tog = 1'b1;
    while (acc < nvec*F_SIZE && acc < max_acc && cyc < 20000) begin
      d_valid = gappy ? tog : 1'b1;
      d_data  = base * (acc / F_SIZE + 1);
      got = d_valid && d_ready;
      tick(); cyc++;
      tog = ~tog;
      if (got) acc++;
    end
    d_valid = 1'b0;
  endtask

  task automatic collect(input int nres, input real base, input bit stall3,
                         input bit check_gap, output int n);
    int cyc, last_cyc;
    real exp_v, hold_data;
    logic [IDX_W-1:0] hold_idx;
    n = 0; cyc = 0; last_cyc = 0; hold_data = 0.0; hold_idx = '0;
    y_bad = 0; hold_bad = 0; gap_bad = 0; stall_seen = 0;
    while (n < nres && cyc < 30000) begin
      y_ready = !(stall3 && y_valid && y_idx == 4'd3 && stall_seen < 5);
      if (y_valid && !y_ready) begin
        if (stall_seen == 0) begin
          hold_data = y_data; hold_idx = y_idx;
        end else if (y_data != hold_data || y_idx !== hold_idx) hold_bad++;
        stall_seen++;
      end
      if (y_valid && y_ready) begin
        exp_v = base * (n / F_NUM + 1) * F_SIZE;
        if (y_data != exp_v || y_idx !== IDX_W'(n % F_NUM)) y_bad++;
        if (stall_seen > 0 && y_idx == 4'd3 && (y_data != hold_data || y_idx !== hold_idx)) hold_bad++;
        if (check_gap && (n % F_NUM) != 0 && (cyc - last_cyc) != 3) gap_bad++;
        last_cyc = cyc;
        n++;
      end
      tick(); cyc++;
    end
    y_ready = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin
      tick(); cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", name, done, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if ({write, init, exec} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got %b want 000", {write, init, exec}); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid got %b want 0", y_valid); end
    checks++; if ({w_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", {w_ready, d_ready}); end
    checks++; if (a !== '0 || y_idx !== '0) begin errors++; $display("FAIL rst_addr a=%0d y_idx=%0d want 0", a, y_idx); end
    checks++; if (w != 0.0 || d != 0.0 || y_data != 0.0) begin errors++; $display("FAIL rst_real w=%f d=%f y=%f want 0", w, d, y_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; load_w = 1'b0; num_vec = '0;
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_busy busy=%b done=%b want 1/0", busy, done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL zero_done busy=%b done=%b want 0/1", busy, done); end
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", busy, done); end
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL b2b_done busy=%b done=%b want 0/1", busy, done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse done=%b want 0", done); end
  endtask

  task automatic test_load();
    int acc, busy0, write0;
    busy0 = mon_busy; write0 = mon_write;
    start_job(1'b1, 16'd0);
    drive_w(1'b1, acc);
    checks++; if (acc != F_NUM*F_SIZE) begin errors++; $display("FAIL load_count got %0d want %0d", acc, F_NUM*F_SIZE); end
    checks++; if (w_bad != 0) begin errors++; $display("FAIL load_write_data bad=%0d want 0", w_bad); end
    tick();
    checks++; if (done !== 1'b1 || write !== 1'b0) begin errors++; $display("FAIL load_done done=%b write=%b want 1/0", done, write); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_pulse done=%b want 0", done); end
    checks++; if (mon_busy - busy0 != 8193) begin errors++; $display("FAIL load_busy_span got %0d want 8193", mon_busy - busy0); end
    checks++; if (mon_write - write0 != 8192) begin errors++; $display("FAIL load_write_pulses got %0d want 8192", mon_write - write0); end
  endtask

  task automatic test_single();
    int acc, accd, n, init0, ebad0, both0;
    start_job(1'b1, 16'd1);
    drive_w(1'b0, acc);
    checks++; if (w_bad != 0 || acc != F_NUM*F_SIZE) begin errors++; $display("FAIL single_wload acc=%0d bad=%0d want 8192/0", acc, w_bad); end
    init0 = mon_init; ebad0 = mon_exec_bad; both0 = mon_both;
    fork
      drive_d(1, 1.0, 1'b0, 1 << 30, accd);
      collect(F_NUM, 1.0, 1'b0, 1'b1, n);
    join
    wait_done("single");
    checks++; if (n != F_NUM) begin errors++; $display("FAIL single_count got %0d want %0d", n, F_NUM); end
    checks++; if (y_bad != 0) begin errors++; $display("FAIL single_y bad=%0d want 0", y_bad); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL single_3cyc bad=%0d want 0", gap_bad); end
    checks++; if (mon_init - init0 != 1) begin errors++; $display("FAIL single_init got %0d want 1", mon_init - init0); end
    checks++; if (mon_exec_bad != ebad0 || mon_both != both0) begin errors++; $display("FAIL single_exec bad=%0d both=%0d want 0", mon_exec_bad - ebad0, mon_both - both0); end
    tick();
  endtask

  task automatic test_backpressure();
    int accd, n, ebad0, bub0;
`ifdef TINY_DNN_CTRL_PERF_EN
    int busy0;
    busy0 = mon_busy;
`endif
    ebad0 = mon_exec_bad; bub0 = mon_bubble;
    start_job(1'b0, 16'd1);
    fork
      drive_d(1, 1.0, 1'b1, 1 << 30, accd);
      collect(F_NUM, 1.0, 1'b1, 1'b0, n);
    join
    wait_done("bp");
    checks++; if (n != F_NUM || y_bad != 0) begin errors++; $display("FAIL bp_y count=%0d bad=%0d want 16/0", n, y_bad); end
    checks++; if (stall_seen != 5 || hold_bad != 0) begin errors++; $display("FAIL bp_hold stalls=%0d bad=%0d want 5/0", stall_seen, hold_bad); end
    checks++; if (mon_exec_bad != ebad0) begin errors++; $display("FAIL bp_bubble_exec bad=%0d want 0", mon_exec_bad - ebad0); end
    checks++; if (mon_bubble - bub0 < 500) begin errors++; $display("FAIL bp_bubbles got %0d want >=500", mon_bubble - bub0); end
`ifdef TINY_DNN_CTRL_PERF_EN
    checks++; if (perf_stall != 32'(mon_bubble - bub0 + 5)) begin errors++; $display("FAIL perf_stall got %0d want %0d", perf_stall, mon_bubble - bub0 + 5); end
    checks++; if (perf_cycles != 32'(mon_busy - busy0)) begin errors++; $display("FAIL perf_cycles got %0d want %0d", perf_cycles, mon_busy - busy0); end
`endif
    tick();
  endtask

  task automatic test_multi();
    int accd, n, init0;
    init0 = mon_init;
    start_job(1'b0, 16'd3);
    fork
      drive_d(3, 1.0, 1'b0, 1 << 30, accd);
      collect(3*F_NUM, 1.0, 1'b0, 1'b0, n);
    join
    wait_done("multi");
    checks++; if (n != 3*F_NUM) begin errors++; $display("FAIL multi_count got %0d want 48", n); end
    checks++; if (y_bad != 0) begin errors++; $display("FAIL multi_y bad=%0d want 0", y_bad); end
    checks++; if (mon_init - init0 != 3) begin errors++; $display("FAIL multi_init got %0d want 3", mon_init - init0); end
    tick();
  endtask

  task automatic test_reset_mid();
    int accd, n;
    start_job(1'b0, 16'd1);
    drive_d(1, 1.0, 1'b0, 100, accd);
    checks++; if (accd != 100) begin errors++; $display("FAIL mid_accepted got %0d want 100", accd); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (exec !== 1'b0 || busy !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL mid_reset exec=%b busy=%b y_valid=%b want 000", exec, busy, y_valid); end
    tick();
    start_job(1'b0, 16'd1);
    fork
      drive_d(1, 2.0, 1'b0, 1 << 30, accd);
      collect(F_NUM, 2.0, 1'b0, 1'b0, n);
    join
    wait_done("mid");
    checks++; if (n != F_NUM || y_bad != 0) begin errors++; $display("FAIL mid_rerun count=%0d bad=%0d want 16/0", n, y_bad); end
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_single();
    test_backpressure();
    test_multi();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
